// File: rtl/inst_fetch.sv
// Instruction-fetch front end: holds the PC, addresses the asynchronous ROM and
// captures each returned word into an IF/ID register handed to decode on valid/allowin.
module inst_fetch #(
   parameter int unsigned ADDR_W   = 5,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              resetn,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_inst,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              id_allowin,
   output logic              if_valid,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_inst,
   output logic [31:0]       fetch_count
);

   localparam int unsigned PC_W = 32;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q;
   logic [PC_W-1:0]   pc_q;
   logic              if_valid_q;
   logic [PC_W-1:0]   if_pc_q;
   logic [31:0]       if_inst_q;
   logic [31:0]       fetch_count_q;

   logic              adv_c;
   logic              handoff_c;
   logic [PC_W-1:0]   redirect_target_c;

   assign adv_c             = (state_q == RUN) && (!if_valid_q || id_allowin);
   assign handoff_c         = if_valid_q && id_allowin;
   assign redirect_target_c = redirect_pc & ~PC_W'(3);

   // ROM address is a plain slice of the PC; out-of-range PCs alias within the ROM.
   assign rom_addr = pc_q[ADDR_W+1:2];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         if_valid_q    <= 1'b0;
         if_pc_q       <= '0;
         if_inst_q     <= '0;
         fetch_count_q <= '0;
      end else begin
         if (handoff_c) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end
         unique case (state_q)
            BOOT: begin
               state_q <= RUN;
               if (redirect_valid) begin
                  pc_q <= redirect_target_c;
               end
            end
            RUN: begin
               // Redirect flushes the held word regardless of decode backpressure.
               if (redirect_valid) begin
                  pc_q       <= redirect_target_c;
                  if_valid_q <= 1'b0;
               end else if (adv_c) begin
                  if_inst_q  <= rom_inst;
                  if_pc_q    <= pc_q;
                  if_valid_q <= 1'b1;
                  pc_q       <= pc_q + PC_W'(4);
               end
            end
            default: begin
               state_q <= BOOT;
            end
         endcase
      end
   end

   assign if_valid    = if_valid_q;
   assign if_pc       = if_pc_q;
   assign if_inst     = if_inst_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed scenarios plus randomized traffic,
// checked against a transaction-level fetch model.
module tb_inst_fetch;

   localparam int unsigned ADDR_W = 5;

   logic              clk = 1'b0;
   logic              resetn;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_inst;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              id_allowin;
   logic              if_valid;
   logic [31:0]       if_pc;
   logic [31:0]       if_inst;
   logic [31:0]       fetch_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] cnt;
   } handoff_t;

   handoff_t exp_q[$];

   // Reference model: boot flag, next fetch address, held entry, delivered count.
   bit          m_boot;
   logic [31:0] m_pc;
   bit          m_hv;
   logic [31:0] m_hpc;
   logic [31:0] m_cnt;

   inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .rom_addr       (rom_addr),
      .rom_inst       (rom_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_allowin     (id_allowin),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   assign rom_inst = 32'hA000_0000 | 32'(rom_addr);

   function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
      return 32'hA000_0000 | ((byte_addr >> 2) & 32'h1F);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_boot = 1'b1;
      m_pc   = 32'h0;
      m_hv   = 1'b0;
      m_hpc  = 32'h0;
      m_cnt  = 32'h0;
      exp_q.delete();
   endtask

   // Apply inputs for one cycle, predict any handoff, then advance the model at the edge.
   task automatic step(input bit allow, input bit rv, input logic [31:0] rpc);
      id_allowin     = allow;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if (m_hv && allow) begin
         handoff_t h;
         h.pc   = m_hpc;
         h.inst = rom_word(m_hpc);
         h.cnt  = m_cnt;
         exp_q.push_back(h);
      end
      @(posedge clk);
      if (m_boot) begin
         m_boot = 1'b0;
         if (rv) m_pc = {rpc[31:2], 2'b00};
      end else begin
         if (m_hv && allow) m_cnt = m_cnt + 1;
         if (rv) begin
            m_pc = {rpc[31:2], 2'b00};
            m_hv = 1'b0;
         end else if (!m_hv || allow) begin
            m_hpc = m_pc;
            m_hv  = 1'b1;
            m_pc  = m_pc + 4;
         end
      end
      #2;
   endtask

   // Monitor: per-cycle state check plus scoreboard pop on every handoff.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         chk("if_valid", 32'(if_valid), 32'(m_hv));
         chk("rom_addr", 32'(rom_addr), (m_pc >> 2) & 32'h1F);
         if (if_valid && id_allowin) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_handoff", 32'(1), 32'(0));
            end else begin
               handoff_t h;
               h = exp_q.pop_front();
               chk("handoff_pc", if_pc, h.pc);
               chk("handoff_inst", if_inst, h.inst);
               chk("handoff_count", fetch_count, h.cnt);
            end
         end
      end
   end

   task automatic run_until_hpc(input logic [31:0] target);
      int guard = 0;
      while (!(m_hv && m_hpc == target) && guard < 200) begin
         step(1'b1, 1'b0, 32'h0);
         guard++;
      end
      chk("reach_pc_timeout", 32'(guard < 200), 32'(1));
   endtask

   task automatic boot_sequence(input string tag);
      step(1'b1, 1'b0, 32'h0);
      chk({tag, "_boot_valid"}, 32'(if_valid), 32'(0));
      step(1'b1, 1'b0, 32'h0);
      chk({tag, "_first_valid"}, 32'(if_valid), 32'(1));
      chk({tag, "_first_pc"}, if_pc, 32'h0);
      chk({tag, "_first_inst"}, if_inst, 32'hA000_0000);
      step(1'b1, 1'b0, 32'h0);
      chk({tag, "_second_pc"}, if_pc, 32'h4);
      chk({tag, "_second_inst"}, if_inst, 32'hA000_0001);
      chk({tag, "_count1"}, fetch_count, 32'd1);
   endtask

   initial begin
      logic [31:0] cnt_hold;
      resetn         = 1'b0;
      id_allowin     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      model_reset();
      #1;
      chk("reset_valid", 32'(if_valid), 32'(0));
      chk("reset_pc", if_pc, 32'h0);
      chk("reset_inst", if_inst, 32'h0);
      chk("reset_count", fetch_count, 32'h0);
      chk("reset_rom_addr", 32'(rom_addr), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #2;
      resetn = 1'b1;

      boot_sequence("init");

      // Backpressure hold on 0x08
      step(1'b1, 1'b0, 32'h0);
      chk("pre_stall_pc", if_pc, 32'h8);
      cnt_hold = fetch_count;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0);
         chk("stall_pc", if_pc, 32'h8);
         chk("stall_inst", if_inst, 32'hA000_0002);
         chk("stall_count", fetch_count, 32'd2);
         chk("stall_rom_addr", 32'(rom_addr), 32'd3);
      end
      step(1'b1, 1'b0, 32'h0);
      chk("post_stall_pc", if_pc, 32'hC);

      // Redirect with no delay slot, low bits ignored
      run_until_hpc(32'h2C);
      step(1'b1, 1'b1, 32'h0000_0045);
      chk("redir_flush", 32'(if_valid), 32'(0));
      chk("redir_rom_addr", 32'(rom_addr), 32'd17);
      step(1'b1, 1'b0, 32'h0);
      chk("redir_pc", if_pc, 32'h44);
      chk("redir_inst", if_inst, 32'hA000_0011);

      // Redirect under backpressure drops the held word uncounted
      cnt_hold = fetch_count;
      step(1'b0, 1'b1, 32'h0000_0100);
      chk("bp_redir_flush", 32'(if_valid), 32'(0));
      chk("bp_redir_count", fetch_count, cnt_hold);
      step(1'b1, 1'b0, 32'h0);
      chk("bp_redir_pc", if_pc, 32'h100);
      chk("bp_redir_inst", if_inst, 32'hA000_0000);

      // Sequential fetch past the ROM size
      step(1'b1, 1'b1, 32'h0000_0078);
      run_until_hpc(32'h7C);
      chk("wrap_rom_addr", 32'(rom_addr), 32'd0);
      step(1'b1, 1'b0, 32'h0);
      chk("beyond_pc", if_pc, 32'h80);
      chk("beyond_inst", if_inst, 32'hA000_0000);

      // 32-bit PC wrap
      step(1'b1, 1'b1, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 32'h0);
      chk("top_pc", if_pc, 32'hFFFF_FFFC);
      chk("top_inst", if_inst, 32'hA000_001F);
      step(1'b1, 1'b0, 32'h0);
      chk("wrap_pc", if_pc, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom);
      end
      chk("model_count", fetch_count, m_cnt);

      // Asynchronous reset in mid-cycle
      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("pre_reset_valid", 32'(if_valid), 32'(1));
      #1;
      resetn = 1'b0;
      model_reset();
      #1;
      chk("async_valid", 32'(if_valid), 32'(0));
      chk("async_count", fetch_count, 32'h0);
      chk("async_rom_addr", 32'(rom_addr), 32'h0);
      chk("async_pc", if_pc, 32'h0);
      @(posedge clk);
      #2;
      resetn = 1'b1;
      boot_sequence("rerun");

      for (int i = 0; i < 200; i++) begin
         step($urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0, $urandom);
      end
      step(1'b0, 1'b0, 32'h0);
      chk("queue_drained", 32'(exp_q.size()), 32'(0));
      chk("final_count", fetch_count, m_cnt);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch initiator for the asynchronous instruction ROM. It holds the PC, drives the ROM word address, and captures the returned instruction into an IF/ID pipeline register that has a valid/allowin handshake toward decode. It accepts branch/jump redirects from later stages and counts delivered instructions for debug.

Parameters:
ADDR_W, 5, ROM word-address width; rom_addr = pc[ADDR_W+1:2]
RESET_PC, 32'h0000_0000, PC value after reset (bits [1:0] must be 0)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
rom_addr  out  ADDR_W  word address to instruction ROM; combinational from pc
rom_inst  in  32  instruction word from ROM; valid in the same cycle as rom_addr
redirect_valid  in  1  branch/jump taken; load redirect_pc
redirect_pc  in  32  redirect target byte address; bits [1:0] ignored
id_allowin  in  1  decode can accept the IF/ID register contents this cycle
if_valid  out  1  IF/ID register holds a valid instruction
if_pc  out  32  byte PC of if_inst
if_inst  out  32  fetched instruction
fetch_count  out  32  number of instructions handed to decode (if_valid && id_allowin)

Behaviour:
- Reset (resetn=0, async): state=BOOT, pc=RESET_PC, if_valid=0, if_pc=0, if_inst=0, fetch_count=0. rom_addr follows pc during reset, giving RESET_PC[ADDR_W+1:2].
- The FSM has two states, BOOT and RUN.
  - BOOT: exactly one cycle after resetn deasserts. No capture, pc held, if_valid=0. Next state is RUN. A redirect in BOOT loads pc and still goes to RUN.
  - RUN: normal operation. It never returns to BOOT except through reset.
- Advance condition: adv = (state==RUN) && (!if_valid || id_allowin).
- Handoff: handoff = if_valid && id_allowin. fetch_count increments by 1 on handoff, wrapping modulo 2^32. It is unaffected by redirect.
- Priority at each rising edge in RUN:
  1. redirect_valid=1:
     - pc <= {redirect_pc[31:2],2'b00}
     - if_valid <= 0, flushing whatever is held, even when id_allowin=0
     - if_pc and if_inst keep their old values
     - there is no delay slot
  2. Else if adv:
     - if_inst <= rom_inst, if_pc <= pc, if_valid <= 1
     - pc <= pc + 4, with 32-bit wrap (0xFFFF_FFFC -> 0)
  3. Else (stall): pc, if_valid, if_pc and if_inst all hold.
- Latency: the word at pc appears on if_inst/if_valid 1 cycle after pc is presented. In steady state with id_allowin=1, throughput is 1 instruction per cycle.
- The first valid instruction after reset release appears on the 2nd rising edge (BOOT then capture).
- After a redirect, the target instruction appears 2 edges after redirect_valid is sampled.
- Out-of-range PC: the address is sliced as-is and rom_addr wraps within ADDR_W. Whatever the ROM returns (0 for unmapped words) is passed through without a fault.
- Stall does not re-read the ROM into the register. if_inst stays stable while if_valid && !id_allowin.
- Reset mid-operation clears everything immediately and restarts at BOOT. An in-flight instruction is lost and not counted.
- if_pc[1:0] and pc[1:0] are always 0.
- All outputs except rom_addr are registered.

Test Plan:
- Bench ROM model returns 32'hA000_0000 | word index. Release reset at edge 0 with id_allowin=1 -> edge 1 if_valid=0 (BOOT). Edge 2: if_valid=1, if_pc=0x00, if_inst=0xA000_0000. Edge 3: if_pc=0x04, if_inst=0xA000_0001. fetch_count=1 after edge 3.
- Run to if_pc=0x08, then hold id_allowin=0 for 3 cycles -> if_pc=0x08, if_inst=0xA000_0002 and pc stay fixed, fetch_count stays constant. After id_allowin=1, the next edge gives if_pc=0x0C.
- With if_pc=0x2C, pulse redirect_valid=1, redirect_pc=0x0000_0045 -> next edge if_valid=0 and pc=0x44. The following edge gives if_pc=0x44, if_inst=0xA000_0011. rom_addr=5'd17 during that cycle.
- Redirect with id_allowin=0 while if_valid=1 -> if_valid drops to 0 at the next edge, the held instruction is not counted, and fetch resumes at the target.
- Sequential fetch past 0x7C (ADDR_W=5) -> pc=0x80 gives rom_addr=0 and if_pc=0x80 (no wrap of pc). A redirect to 0xFFFF_FFFC followed by 2 advances gives if_pc=0xFFFF_FFFC then if_pc=0x0000_0000.
- Assert resetn=0 asynchronously mid-cycle while if_valid=1 -> if_valid, fetch_count and pc clear immediately without waiting for a clock edge. After release, the BOOT cycle and first fetch at RESET_PC repeat.
